// File: rtl/nibble_bus_master.sv
// nibble_bus_master: parametrised master for the multiplexed address/IO/data nibble bus
// Ports: clk; reset_n (synchronous, active low);
//   req_valid/req_ready/req_write/req_io/req_addr/req_wdata: request handshake;
//   rsp_valid/rsp_rdata/rsp_err/rsp_io_ready/rsp_io_skip: completion pulse and results;
//   pin_in/pin_wait: external lanes and wait request; pin_out: {type[1:0], last, write, payload}.
// Option: NBUS_ADDR_CACHE_EN skips the upper address beats when they repeat the last ones sent.
module nibble_bus_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int ADDR_LANE_W = 6,
  parameter int LANE_W = 4,
  parameter int DEV_W = 6,
  parameter int WAIT_MAX = 15,
  localparam int AB = (ADDR_W + ADDR_LANE_W - 1) / ADDR_LANE_W,
  localparam int DB = (DATA_W + LANE_W - 1) / LANE_W,
  localparam int PW0 = ADDR_LANE_W > LANE_W ? ADDR_LANE_W : LANE_W,
  localparam int PW = PW0 > DEV_W ? PW0 : DEV_W,
  localparam int OUT_W = PW + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_io_ready,
  output logic              rsp_io_skip,
  input  logic [LANE_W-1:0] pin_in,
  input  logic              pin_wait,
  output logic [OUT_W-1:0]  pin_out
);
  localparam int AW = AB * ADDR_LANE_W;
  localparam int DW = DB * LANE_W;
  localparam int BW = $clog2(AB + DB + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_IOB = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4;
  logic [2:0] state;
  logic [BW-1:0] beat;
  logic [WW-1:0] wcnt;
  logic rdy_en, wr, accept, hit, abort, a_last, d_last;
  logic [DEV_W-1:0] dev;
  logic [AW-1:0] ash, apad;
  logic [DW-1:0] wsh, rbuf, rshift;
  // Address and write data are zero-padded at the top and shifted left per beat,
  // so the outgoing slice is always the top lane (MS slice first).
  assign apad = AW'(req_addr);
  // Read beats arrive MS first; shifting in from the bottom leaves them in place after DB beats.
  assign rshift = DW'({rbuf, pin_in});
  assign req_ready = rdy_en && (state == S_IDLE || state == S_DONE);
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == S_DONE;
  assign a_last = beat == BW'(AB - 1);
  assign d_last = beat == BW'(DB - 1);
  assign abort = state == S_DATA && pin_wait && wcnt == WW'(WAIT_MAX - 1);
  assign pin_out = state == S_ADDR ? {2'b01, a_last, wr, PW'(ash[AW-1 -: ADDR_LANE_W])}
                 : state == S_IOB  ? {2'b10, 1'b1, wr, PW'(dev)}
                 : state == S_DATA ? {2'b11, d_last, wr, wr ? PW'(wsh[DW-1 -: LANE_W]) : PW'(0)}
                 : OUT_W'(0);
`ifdef NBUS_ADDR_CACHE_EN
  localparam int CW = AB > 1 ? (AB - 1) * ADDR_LANE_W : 1;
  logic c_valid;
  logic [CW-1:0] c_tag;
  assign hit = c_valid && !req_io && c_tag == apad[AW-1 -: CW];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_valid <= 1'b0;
      c_tag <= '0;
    end else if (abort) begin
      c_valid <= 1'b0;
    end else if (accept && !req_io) begin
      c_valid <= 1'b1;
      c_tag <= apad[AW-1 -: CW];
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      beat <= '0;
      wcnt <= '0;
      rdy_en <= 1'b0;
      wr <= 1'b0;
      dev <= '0;
      ash <= '0;
      wsh <= '0;
      rbuf <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_io_ready <= 1'b0;
      rsp_io_skip <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          rsp_err <= 1'b0;
          state <= accept ? (req_io ? S_IOB : S_ADDR) : S_IDLE;
          if (accept) begin
            wr <= req_write;
            dev <= req_addr[DEV_W-1:0];
            wsh <= DW'(req_wdata);
            // On a cache hit only the LS address slice goes out, so start at the last beat.
            ash <= hit ? apad << ((AB - 1) * ADDR_LANE_W) : apad;
            beat <= hit ? BW'(AB - 1) : '0;
          end
        end
        S_ADDR: begin
          ash <= ash << ADDR_LANE_W;
          beat <= a_last ? '0 : beat + BW'(1);
          if (a_last) state <= S_DATA;
        end
        S_IOB: begin
          rsp_io_ready <= pin_in[0];
          rsp_io_skip <= pin_in[1];
          state <= S_DATA;
        end
        S_DATA: begin
          if (pin_wait) begin
            wcnt <= abort ? '0 : wcnt + WW'(1);
            if (abort) begin
              state <= S_DONE;
              rsp_err <= 1'b1;
            end
          end else begin
            wcnt <= '0;
            rbuf <= rshift;
            wsh <= wsh << LANE_W;
            beat <= beat + BW'(1);
            if (d_last) begin
              state <= S_DONE;
              if (!wr) rsp_rdata <= rshift[DATA_W-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_bus_master.sv
// tb_nibble_bus_master: randomized scoreboard bench for nibble_bus_master
module tb_nibble_bus_master;
  localparam int AB = 2, DB = 3, WAIT_MAX = 15;
  logic clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_write = 1'b0, req_io = 1'b0, pin_wait = 1'b0;
  logic [11:0] req_addr = '0, req_wdata = '0;
  logic [3:0] pin_in = '0;
  logic req_ready, rsp_valid, rsp_err, rsp_io_ready, rsp_io_skip;
  logic [11:0] rsp_rdata;
  logic [9:0] pin_out;
  int total = 0, bad = 0, cyc = 0;
  bit mon_on = 1'b0;
  typedef struct { int c; logic [9:0] v; } beat_t;
  typedef struct { int c; logic [11:0] d; logic e; logic r; logic s; } rsp_t;
  beat_t beat_q[$];
  rsp_t rsp_q[$];
  beat_t mb;
  rsp_t mr;
  logic [11:0] m_rd = '0;
  logic m_ior = 1'b0, m_ios = 1'b0, c_ok = 1'b0;
  logic [5:0] c_tag = '0;
  int wt[DB];

  nibble_bus_master dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_io_ready(rsp_io_ready), .rsp_io_skip(rsp_io_skip),
    .pin_in(pin_in), .pin_wait(pin_wait), .pin_out(pin_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on && (pin_out !== 10'h0 || (beat_q.size() > 0 && beat_q[0].c <= cyc))) begin
      total++;
      if (beat_q.size() == 0) begin
        bad++;
        $display("FAIL beat cyc=%0d got=%h required=idle", cyc, pin_out);
      end else begin
        mb = beat_q.pop_front();
        if (mb.c != cyc || mb.v !== pin_out) begin
          bad++;
          $display("FAIL beat cyc=%0d got=%h required=%h at cyc %0d", cyc, pin_out, mb.v, mb.c);
        end
      end
    end
    if (mon_on && (rsp_valid === 1'b1 || (rsp_q.size() > 0 && rsp_q[0].c <= cyc))) begin
      total++;
      if (rsp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp cyc=%0d got=unexpected rsp_valid required=none", cyc);
      end else begin
        mr = rsp_q.pop_front();
        if (mr.c != cyc || rsp_valid !== 1'b1 || mr.d !== rsp_rdata || mr.e !== rsp_err ||
            mr.r !== rsp_io_ready || mr.s !== rsp_io_skip) begin
          bad++;
          $display("FAIL rsp cyc=%0d got v=%b d=%h e=%b r=%b s=%b required cyc=%0d d=%h e=%b r=%b s=%b",
                   cyc, rsp_valid, rsp_rdata, rsp_err, rsp_io_ready, rsp_io_skip, mr.c, mr.d, mr.e, mr.r, mr.s);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic logic [9:0] dbeat(input logic wr, input int i, input logic [11:0] wd);
    return {2'b11, i == DB - 1, wr, wr ? 6'((wd >> (4 * (DB - 1 - i))) & 12'hF) : 6'd0};
  endfunction

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request, predict every bus beat and the response, then drive the pins.
  // dp/ip fix read-beat and IO-beat pin values when fix=1; rst_db>=0 resets during that data beat.
  task automatic txn(input logic wr, input logic io, input logic [11:0] addr, input logic [11:0] wd,
                     input logic [11:0] dp, input logic [3:0] ip, input bit fix, input int rst_db);
    int ta, n, rst_off;
    logic err, hit;
    logic [11:0] rd;
    logic [3:0] p;
    beat_t eb[$];
    logic [3:0] din[$];
    logic dwt[$];
    req_write = wr;
    req_io = io;
    req_addr = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept got=req_ready %b required=1", req_ready);
      req_valid = 1'b0;
      return;
    end
    ta = cyc;
    n = 0;
    err = 1'b0;
    rd = m_rd;
    if (io) begin
      p = fix ? ip : 4'($urandom);
      eb.push_back('{ta + 1, {2'b10, 1'b1, wr, addr[5:0]}});
      din.push_back(p);
      dwt.push_back(1'($urandom));
      m_ior = p[0];
      m_ios = p[1];
      n = 1;
    end else begin
`ifdef NBUS_ADDR_CACHE_EN
      hit = c_ok && c_tag == addr[11:6];
`else
      hit = 1'b0;
`endif
      for (int i = hit ? AB - 1 : 0; i < AB; i++) begin
        eb.push_back('{ta + 1 + n, {2'b01, i == AB - 1, wr, 6'(addr >> (6 * (AB - 1 - i)))}});
        din.push_back(4'($urandom));
        dwt.push_back(1'($urandom));
        n++;
      end
      c_ok = 1'b1;
      c_tag = addr[11:6];
    end
    rst_off = rst_db < 0 ? -1 : n + rst_db;
    for (int i = 0; i < DB && !err; i++) begin
      for (int j = 0; j < wt[i] && j < WAIT_MAX; j++) begin
        eb.push_back('{ta + 1 + n, dbeat(wr, i, wd)});
        din.push_back(4'($urandom));
        dwt.push_back(1'b1);
        n++;
      end
      if (wt[i] >= WAIT_MAX) err = 1'b1;
      else begin
        p = fix ? 4'(dp >> (4 * (DB - 1 - i))) : 4'($urandom);
        eb.push_back('{ta + 1 + n, dbeat(wr, i, wd)});
        din.push_back(p);
        dwt.push_back(1'b0);
        rd = 12'((rd << 4) | 12'(p));
        n++;
      end
    end
    if (err) c_ok = 1'b0;
    if (!wr && !err) m_rd = rd;
    for (int i = 0; i < n && (rst_off < 0 || i <= rst_off); i++) beat_q.push_back(eb[i]);
    if (rst_off < 0) rsp_q.push_back('{ta + 1 + n, m_rd, err, m_ior, m_ios});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_io = 1'($urandom);
    req_addr = 12'($urandom);
    req_wdata = 12'($urandom);
    for (int i = 0; i < n; i++) begin
      pin_in = din[i];
      pin_wait = dwt[i];
      if (i == rst_off) reset_n = 1'b0;
      tick(1);
      if (i == rst_off) break;
    end
    pin_in = 4'($urandom);
    pin_wait = 1'($urandom);
    if (rst_off >= 0) begin
      @(negedge clk);
      chk("rst_pin_out", 32'(pin_out), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      m_rd = '0;
      m_ior = 1'b0;
      m_ios = 1'b0;
      c_ok = 1'b0;
      reset_n = 1'b1;
      tick(1);
      @(negedge clk);
      chk("rst_ready_after", 32'(req_ready), 1);
      tick(1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DB; i++) wt[i] = 0;
    tick(3);
    @(negedge clk);
    chk("reset_pin_out", 32'(pin_out), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_io_ready", 32'(rsp_io_ready), 0);
    chk("reset_io_skip", 32'(rsp_io_skip), 0);
    reset_n = 1'b1;
    tick(1);
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);
    mon_on = 1'b1;
    tick(1);
    txn(1'b0, 1'b0, 12'o1234, 12'h000, 12'h5A3, 4'h0, 1'b1, -1);
    txn(1'b1, 1'b0, 12'o0100, 12'hFED, 12'h000, 4'h0, 1'b1, -1);
    txn(1'b0, 1'b1, 12'o0003, 12'h000, 12'h9C4, 4'b0001, 1'b1, -1);
    tick(2);
    wt[1] = 3;
    txn(1'b0, 1'b0, 12'o4321, 12'h000, 12'h1E7, 4'h0, 1'b1, -1);
    wt[1] = WAIT_MAX;
    txn(1'b0, 1'b0, 12'o4322, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    wt[1] = 0;
    txn(1'b0, 1'b0, 12'o0200, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    txn(1'b0, 1'b0, 12'o0201, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    wt[0] = WAIT_MAX;
    txn(1'b0, 1'b0, 12'o0200, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    wt[0] = 0;
    txn(1'b0, 1'b0, 12'o0201, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < DB; i++) wt[i] = $urandom_range(0, 6) == 0 ? int'($urandom_range(0, WAIT_MAX)) : 0;
      txn(1'($urandom), $urandom_range(0, 3) == 0, {6'($urandom_range(0, 2)), 6'($urandom)},
          12'($urandom), 12'h000, 4'h0, 1'b0, -1);
      tick($urandom_range(0, 2));
    end
    for (int i = 0; i < DB; i++) wt[i] = 0;
    txn(1'b0, 1'b0, 12'o1234, 12'h000, 12'h000, 4'h0, 1'b0, 1);
    txn(1'b1, 1'b0, 12'o1234, 12'h0AB, 12'h000, 4'h0, 1'b0, -1);
    txn(1'b0, 1'b1, 12'o0077, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    txn(1'b0, 1'b0, 12'o1235, 12'h000, 12'h000, 4'h0, 1'b0, -1);
    tick(4);
    chk("drain", 32'(beat_q.size() + rsp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
